// File: rtl/game_pkg.sv
// Shared constants and state encoding for the frog game-flow controller.
package game_pkg;

    localparam int WATERFALL = 0;
    localparam int FRENCH    = 1;
    localparam int LOG       = 2;
    localparam int FROG      = 3;
    localparam int ENDBANK   = 4;

    localparam logic [9:0] WIN_FREQ  = 10'd1;
    localparam logic [9:0] LOSE_FREQ = 10'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_WIN,
        ST_LOSE,
        ST_BUZ,
        ST_GAMEOVER
    } game_state_e;

endpackage

// File: rtl/obj_priority_mux.sv
// Per-pixel layer priority encoder: 0 = background, else index of the
// lowest-numbered active layer plus one.
module obj_priority_mux #(
    parameter int NUM_OBJ = 6
) (
    input  logic [NUM_OBJ-1:0] draw_req,
    output logic [7:0]         select_mux
);

    always_comb begin
        select_mux = 8'd0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (draw_req[i]) select_mux = 8'(i + 1);
        end
    end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: layer priority, per-frame collision verdict, level/lives
// tracking and buzzer timing. Optional lives/game-over feature: GAME_LIVES_EN.
module game_ctrl_fsm #(
    parameter int                   NUM_OBJ        = 6,
    parameter int                   FROG_IDX       = game_pkg::FROG,
    parameter logic [NUM_OBJ-1:0]   HAZARD_MASK    = 6'b000101,
    parameter logic [NUM_OBJ-1:0]   GOAL_MASK      = 6'b010000,
    parameter int                   LOG_NUM        = 30,
    parameter int                   LOGS_PER_LEVEL = 3,
    parameter int                   MAX_LEVEL      = 10,
    parameter int                   LIVES          = 3,
    parameter int                   BUZ_CYCLES     = 50_000_000,
    parameter logic [9:0]           WIN_FREQ       = game_pkg::WIN_FREQ,
    parameter logic [9:0]           LOSE_FREQ      = game_pkg::LOSE_FREQ,
    localparam int                  LVL_W          = $clog2(MAX_LEVEL + 1),
    localparam int                  LIVES_W        = $clog2(LIVES + 1)
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                start,
    input  logic                frame_end,
    input  logic [NUM_OBJ-1:0]  draw_req,
    output logic [7:0]          select_mux,
    output logic                win,
    output logic                lose,
    output logic                game_over,
    output logic [LVL_W-1:0]    level_out,
    output logic [LIVES_W-1:0]  lives_out,
    output logic [LOG_NUM-1:0]  log_enable_out,
    output logic [9:0]          sound_freq_out,
    output logic                enable_sound
);

    import game_pkg::*;

    localparam int CNT_W = (BUZ_CYCLES > 1) ? $clog2(BUZ_CYCLES) : 1;

    game_state_e        state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [9:0]         sound_q, sound_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_haz_q, hit_haz_d;
    logic               hit_goal_q, hit_goal_d;
    logic               haz_now, goal_now;
`ifdef GAME_LIVES_EN
    logic [LIVES_W-1:0] lives_q, lives_d;
`endif

    obj_priority_mux #(.NUM_OBJ(NUM_OBJ)) u_prio (
        .draw_req   (draw_req),
        .select_mux (select_mux)
    );

    assign haz_now  = draw_req[FROG_IDX] & (|(draw_req & HAZARD_MASK));
    assign goal_now = draw_req[FROG_IDX] & (|(draw_req & GOAL_MASK));

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        sound_d    = sound_q;
        cnt_d      = cnt_q;
        hit_haz_d  = 1'b0;
        hit_goal_d = 1'b0;
`ifdef GAME_LIVES_EN
        lives_d    = lives_q;
`endif
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                hit_haz_d  = hit_haz_q | haz_now;
                hit_goal_d = hit_goal_q | goal_now;
                // Verdict includes this cycle's pixel; hazard wins over goal.
                if (frame_end) begin
                    hit_haz_d  = 1'b0;
                    hit_goal_d = 1'b0;
                    if (hit_haz_q | haz_now)        state_d = ST_LOSE;
                    else if (hit_goal_q | goal_now) state_d = ST_WIN;
                end
            end
            ST_WIN: begin
                if (level_q < LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
                sound_d = WIN_FREQ;
                cnt_d   = CNT_W'(BUZ_CYCLES - 1);
                state_d = ST_BUZ;
            end
            ST_LOSE: begin
                sound_d = LOSE_FREQ;
                cnt_d   = CNT_W'(BUZ_CYCLES - 1);
`ifdef GAME_LIVES_EN
                if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
`else
                if (level_q > LVL_W'(1)) level_d = level_q - LVL_W'(1);
`endif
                state_d = ST_BUZ;
            end
            ST_BUZ: begin
                if (cnt_q == '0) begin
`ifdef GAME_LIVES_EN
                    state_d = (lives_q == '0) ? ST_GAMEOVER : ST_PLAY;
`else
                    state_d = ST_PLAY;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAMEOVER: begin
                if (start) begin
                    level_d = LVL_W'(1);
`ifdef GAME_LIVES_EN
                    lives_d = LIVES_W'(LIVES);
`endif
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q    <= ST_IDLE;
            level_q    <= LVL_W'(1);
            sound_q    <= '0;
            cnt_q      <= '0;
            hit_haz_q  <= 1'b0;
            hit_goal_q <= 1'b0;
`ifdef GAME_LIVES_EN
            lives_q    <= LIVES_W'(LIVES);
`endif
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            sound_q    <= sound_d;
            cnt_q      <= cnt_d;
            hit_haz_q  <= hit_haz_d;
            hit_goal_q <= hit_goal_d;
`ifdef GAME_LIVES_EN
            lives_q    <= lives_d;
`endif
        end
    end

    // Thermometer of enabled logs, saturating at the full mask width.
    always_comb begin
        int n;
        n = 32'(level_q) * LOGS_PER_LEVEL;
        if (n > LOG_NUM) n = LOG_NUM;
        log_enable_out = '0;
        for (int i = 0; i < LOG_NUM; i++) log_enable_out[i] = (i < n);
    end

    assign win            = (state_q == ST_WIN);
    assign lose           = (state_q == ST_LOSE);
    assign enable_sound   = (state_q == ST_BUZ);
    assign level_out      = level_q;
    assign sound_freq_out = sound_q;
`ifdef GAME_LIVES_EN
    assign lives_out      = lives_q;
    assign game_over      = (state_q == ST_GAMEOVER);
`else
    assign lives_out      = LIVES_W'(LIVES);
    assign game_over      = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm with a 5-cycle buzzer.
module tb_game_ctrl_fsm;

    localparam int BUZ = 5;
    localparam int W   = 27;   // {is_win, level[7:0], lives[7:0], sound[9:0]}

    logic        clk = 1'b0;
    logic        rst, start, frame_end;
    logic [5:0]  draw_req;
    logic [7:0]  select_mux;
    logic        win, lose, game_over, enable_sound;
    logic [3:0]  level_out;
    logic [1:0]  lives_out;
    logic [29:0] log_enable_out;
    logic [9:0]  sound_freq_out;

    game_ctrl_fsm #(.BUZ_CYCLES(BUZ)) dut (
        .clk            (clk),
        .resetN         (rst),
        .start          (start),
        .frame_end      (frame_end),
        .draw_req       (draw_req),
        .select_mux     (select_mux),
        .win            (win),
        .lose           (lose),
        .game_over      (game_over),
        .level_out      (level_out),
        .lives_out      (lives_out),
        .log_enable_out (log_enable_out),
        .sound_freq_out (sound_freq_out),
        .enable_sound   (enable_sound)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_sel(input logic [5:0] d);
        for (int i = 0; i < 6; i++) if (d[i]) return 8'(i + 1);
        return 8'd0;
    endfunction

    function automatic logic [29:0] ref_mask(input int lvl);
        logic [63:0] m;
        int n;
        n = lvl * 3;
        if (n > 30) n = 30;
        m = (64'd1 << n) - 64'd1;
        return m[29:0];
    endfunction

    // bench model
    int  m_level = 1;
    int  m_lives = 3;
    int  m_sound = 0;
    bit  m_in_play = 0;
    bit  lives_en;
    initial begin
`ifdef GAME_LIVES_EN
        lives_en = 1;
`else
        lives_en = 0;
`endif
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    bit           pending = 0;
    int           fe_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
        end else if (pending) begin
            check("level_after_evt", 32'(level_out), 32'(cur[25:18]));
            check("lives_after_evt", 32'(lives_out), 32'(cur[17:10]));
            check("sound_after_evt", 32'(sound_freq_out), 32'(cur[9:0]));
            check("buz_start", 32'(enable_sound), 32'd1);
            pending = 0;
        end else if (win || lose) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {30'd0, win, lose}, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check("evt_kind", {30'd0, win, lose}, cur[26] ? 32'd2 : 32'd1);
                check("evt_latency", 32'(cyc - fe_cyc), 32'd1);
                pending = 1;
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; start = 0; frame_end = 0; draw_req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_level = 1; m_lives = 3; m_sound = 0; m_in_play = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        m_level = 1; m_lives = 3; m_in_play = 1;
    endtask

    task automatic play_frame(input bit haz, input bit goal, input bit late, input bit wait_buz);
        bit ev, is_win;
        int n;
        repeat (4) begin
            @(posedge clk); #1;
            draw_req = 6'($urandom_range(0, 63)) & ~6'b001000;
            #1 check("sel_rand", 32'(select_mux), 32'(ref_sel(draw_req)));
        end
        if (!late && haz)  begin @(posedge clk); #1 draw_req = 6'b001100; end
        if (!late && goal) begin @(posedge clk); #1 draw_req = 6'b011000; end
        @(posedge clk); #1;
        draw_req  = late ? (6'b001000 | (haz ? 6'b000100 : 6'b0) | (goal ? 6'b010000 : 6'b0))
                         : 6'b0;
        frame_end = 1;
        fe_cyc    = cyc;
        ev = m_in_play && (haz || goal);
        is_win = !haz;
        if (ev) begin
            if (is_win) begin
                if (m_level < 10) m_level++;
                m_sound = 1;
            end else begin
                m_sound = 0;
                if (lives_en) begin
                    if (m_lives > 0) m_lives--;
                    if (m_lives == 0) m_in_play = 0;
                end else if (m_level > 1) begin
                    m_level--;
                end
            end
            exp_q.push_back({is_win, 8'(m_level), 8'(m_lives), 10'(m_sound)});
        end
        @(posedge clk); #1 frame_end = 0; draw_req = '0;
        if (ev && wait_buz) begin
            n = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (enable_sound) n++;
                else if (n > 0) break;
            end
            check("buz_len", 32'(n), 32'(BUZ));
            check("game_over", 32'(game_over), 32'(lives_en && m_lives == 0));
            check("log_mask", 32'(log_enable_out), 32'(ref_mask(m_level)));
        end else begin
            repeat (3) @(negedge clk);
            check("no_evt_quiet", {30'd0, win, lose}, 32'd0);
        end
    endtask

    // stimulus
    initial begin
        rst = 1; start = 0; frame_end = 0; draw_req = '0;
        do_reset();
        @(negedge clk);
        check("rst_win", 32'(win), 32'd0);
        check("rst_lose", 32'(lose), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_sound_en", 32'(enable_sound), 32'd0);
        check("rst_level", 32'(level_out), 32'd1);
        check("rst_lives", 32'(lives_out), 32'd3);
        check("rst_log", 32'(log_enable_out), 32'h7);
        check("rst_freq", 32'(sound_freq_out), 32'd0);

        draw_req = 6'b011000; #1 check("sel_frog_bank", 32'(select_mux), 32'd4);
        draw_req = 6'b000000; #1 check("sel_bg", 32'(select_mux), 32'd0);
        draw_req = 6'b100000; #1 check("sel_top", 32'(select_mux), 32'd6);

        // frame_end ignored in IDLE
        play_frame(1, 0, 0, 1);

        pulse_start();
        play_frame(1, 0, 0, 1);   // frog on log -> lose
        play_frame(0, 1, 0, 1);   // end bank -> win
        play_frame(1, 1, 0, 1);   // hazard beats goal
        play_frame(0, 0, 0, 1);   // clean frame
        play_frame(0, 1, 1, 1);   // goal on the frame_end pixel
        play_frame(1, 1, 1, 1);   // both on the frame_end pixel

        if (lives_en) begin
            while (m_in_play) play_frame(1, 0, 0, 1);
            play_frame(1, 0, 0, 1);   // ignored in GAMEOVER
            check("go_held", 32'(game_over), 32'd1);
            pulse_start();
            @(negedge clk);
            check("restart_go", 32'(game_over), 32'd0);
            check("restart_level", 32'(level_out), 32'd1);
            check("restart_lives", 32'(lives_out), 32'd3);
        end

        for (int i = 0; i < 11; i++) play_frame(0, 1, 0, 1);
        check("level_sat", 32'(level_out), 32'd10);
        check("log_full", 32'(log_enable_out), 32'h3FFF_FFFF);

        // reset while buzzing
        play_frame(0, 1, 0, 0);
        do_reset();
        @(negedge clk);
        check("abort_sound_en", 32'(enable_sound), 32'd0);
        check("abort_level", 32'(level_out), 32'd1);
        check("abort_freq", 32'(sound_freq_out), 32'd0);
        pulse_start();
        play_frame(0, 1, 0, 1);
        check("post_abort_level", 32'(level_out), 32'd2);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
